// File: rtl/aes_inv_controller.sv
// Sequencer for the AES-128 inverse cipher: runs the key schedule forward into the
// round-key store, then replays keys 10..0 while stepping the inverse round datapath.
module aes_inv_controller #(
   parameter int unsigned SBOX_LAT = 3
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       load_i,
   output logic [3:0] round_o,
   output logic       kexp_o,
   output logic       ks_we_o,
   output logic       init_en_o,
   output logic       round_en_o,
   output logic       last_round_o,
   output logic       done_o
);

   localparam int unsigned NR = 10;
   // A zero-latency sbox still needs a one-bit counter to keep the types legal.
   localparam int unsigned CntW = (SBOX_LAT > 0) ? $clog2(SBOX_LAT + 1) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(SBOX_LAT);
   localparam logic [3:0] LastRound = 4'(NR);

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StKexp = 3'd1,
      StInit = 3'd2,
      StDec  = 3'd3,
      StLast = 3'd4,
      StDone = 3'd5
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      round_q, round_d;
   logic            load_q;
   logic            start;
   logic            round_end;

   assign start     = load_i & ~load_q;
   assign round_end = (cnt_q == CntMax);
   assign round_o   = round_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         round_q <= '0;
         load_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         round_q <= round_d;
         load_q  <= load_i;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = '0;
      round_d      = round_q;
      kexp_o       = 1'b0;
      ks_we_o      = 1'b0;
      init_en_o    = 1'b0;
      round_en_o   = 1'b0;
      last_round_o = 1'b0;
      done_o       = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StKexp;
               round_d = '0;
            end
         end
         StKexp: begin
            kexp_o = 1'b1;
            // Round 0 is the raw key: stored in one cycle, no sbox wait.
            if (round_q == 4'd0) begin
               ks_we_o = 1'b1;
               round_d = 4'd1;
            end else if (round_end) begin
               ks_we_o = 1'b1;
               if (round_q == LastRound) begin
                  state_d = StInit;
               end else begin
                  round_d = round_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StInit: begin
            init_en_o = 1'b1;
            state_d   = StDec;
            round_d   = LastRound - 4'd1;
         end
         StDec: begin
            if (round_end) begin
               round_en_o = 1'b1;
               round_d    = round_q - 4'd1;
               if (round_q == 4'd1) begin
                  state_d = StLast;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StLast: begin
            last_round_o = 1'b1;
            if (round_end) begin
               round_en_o = 1'b1;
               state_d    = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            done_o = 1'b1;
            if (start) begin
               state_d = StKexp;
               round_d = '0;
            end
         end
         default: begin
            state_d = StIdle;
            round_d = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_aes_inv_controller.sv
// Bench for aes_inv_controller: two builds (SBOX_LAT 3 and 0) checked every cycle
// against a schedule model, plus literal latency and strobe-order checks.
module tb_aes_inv_controller;

   logic clk = 1'b0;
   logic rst_n;
   logic load;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [3:0] round3, round0;
   logic kexp3, ks_we3, init3, ren3, last3, done3;
   logic kexp0, ks_we0, init0, ren0, last0, done0;

   aes_inv_controller #(.SBOX_LAT(3)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .load_i(load), .round_o(round3), .kexp_o(kexp3),
      .ks_we_o(ks_we3), .init_en_o(init3), .round_en_o(ren3), .last_round_o(last3),
      .done_o(done3)
   );

   aes_inv_controller #(.SBOX_LAT(0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .load_i(load), .round_o(round0), .kexp_o(kexp0),
      .ks_we_o(ks_we0), .init_en_o(init0), .round_en_o(ren0), .last_round_o(last0),
      .done_o(done0)
   );

   // Model: phase 0 idle, 1 running (t cycles since start edge), 2 done.
   int   ph3, t3, ph0, t0;
   logic lq;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph3 <= 0; t3 <= 0; ph0 <= 0; t0 <= 0; lq <= 1'b0;
      end else begin
         lq <= load;
         if (ph3 != 1) begin
            if (load && !lq) begin ph3 <= 1; t3 <= 0; end
         end else if (t3 == 20 * 3 + 21) ph3 <= 2;
         else t3 <= t3 + 1;
         if (ph0 != 1) begin
            if (load && !lq) begin ph0 <= 1; t0 <= 0; end
         end else if (t0 == 21) ph0 <= 2;
         else t0 <= t0 + 1;
      end
   end

   // {round[3:0], kexp, ks_we, init_en, round_en, last_round, done}
   function automatic logic [9:0] exp_out(input int ph, input int t, input int lat);
      logic [9:0] o;
      int rl, u, r;
      o  = '0;
      rl = lat + 1;
      if (ph == 2) begin
         o[0] = 1'b1;
      end else if (ph == 1) begin
         if (t == 0) begin
            o[5] = 1'b1; o[4] = 1'b1;
         end else if (t <= 10 * rl) begin
            r = 1 + (t - 1) / rl;
            o[9:6] = r[3:0]; o[5] = 1'b1; o[4] = ((t - 1) % rl == lat);
         end else if (t == 10 * rl + 1) begin
            r = 10;
            o[9:6] = r[3:0]; o[3] = 1'b1;
         end else begin
            u = t - (10 * rl + 2);
            r = 9 - u / rl;
            o[9:6] = r[3:0]; o[2] = (u % rl == lat); o[1] = (r == 0);
         end
      end
      return o;
   endfunction

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, got, want);
      end
   endtask

   task automatic tick();
      logic [9:0] g3, g0, e3, e0;
      @(negedge clk);
      g3 = {round3, kexp3, ks_we3, init3, ren3, last3, done3};
      g0 = {round0, kexp0, ks_we0, init0, ren0, last0, done0};
      e3 = exp_out(ph3, t3, 3);
      e0 = exp_out(ph0, t0, 0);
      checks += 2;
      if (g3 !== e3) begin
         errors++;
         $display("FAIL outputs_lat3 at cyc %0d: got %b, expected %b", cyc, g3, e3);
      end
      if (g0 !== e0) begin
         errors++;
         $display("FAIL outputs_lat0 at cyc %0d: got %b, expected %b", cyc, g0, e0);
      end
      chk("strobe_excl_lat3", int'($onehot0({ks_we3, init3, ren3})), 1);
   endtask

   int ks_q[$];
   int init_q[$];
   int ren_q[$];
   int s0, lat3, lat0;
   bit found;

   initial begin
      rst_n = 1'b0;
      load  = 1'b0;
      // Reset holds everything at zero regardless of load activity.
      repeat (2) tick();
      load = 1'b1;
      tick();
      load = 1'b0;
      tick();
      chk("reset_outputs_lat3", int'({round3, kexp3, ks_we3, init3, ren3, last3, done3}), 0);
      chk("reset_outputs_lat0", int'({round0, kexp0, ks_we0, init0, ren0, last0, done0}), 0);
      rst_n = 1'b1;
      repeat (2) tick();
      chk("idle_no_done", int'(done3), 0);

      // Run 1: re-pulse at cycle 30 ignored; load held high from 70 past done.
      load = 1'b1;
      s0   = cyc + 1;
      lat3 = -1;
      lat0 = -1;
      for (int i = 0; i <= 120; i++) begin
         tick();
         if (ks_we3) ks_q.push_back(int'(round3));
         if (init3) init_q.push_back(int'(round3));
         if (ren3) ren_q.push_back(int'(round3));
         if (done3 && lat3 < 0) lat3 = cyc - s0;
         if (done0 && lat0 < 0) lat0 = cyc - s0;
         if (i == 2) load = 1'b0;
         if (i == 30) load = 1'b1;
         if (i == 31) load = 1'b0;
         if (i == 70) load = 1'b1;
      end
      chk("latency_lat3", lat3, 82);
      chk("latency_lat0", lat0, 22);
      chk("ks_we_count", ks_q.size(), 11);
      foreach (ks_q[k]) chk("ks_we_round", ks_q[k], k);
      chk("init_count", init_q.size(), 1);
      if (init_q.size() > 0) chk("init_round", init_q[0], 10);
      chk("round_en_count", ren_q.size(), 10);
      foreach (ren_q[k]) chk("round_en_round", ren_q[k], (k < 9) ? 9 - k : 0);
      chk("done_held_with_load_high", int'(done3), 1);

      // Run 2: reset in the middle of decryption round 5.
      load = 1'b0;
      tick();
      load = 1'b1;
      tick();
      load  = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick();
         if (round3 == 4'd5 && !kexp3 && !done3) found = 1'b1;
      end
      chk("reached_dec_round5", int'(found), 1);
      rst_n = 1'b0;
      tick();
      chk("abort_outputs_lat3", int'({round3, kexp3, ks_we3, init3, ren3, last3, done3}), 0);
      rst_n = 1'b1;
      tick();

      // Run 3: full sequence again after the abort.
      load = 1'b1;
      s0   = cyc + 1;
      lat3 = -1;
      lat0 = -1;
      for (int i = 0; i <= 90; i++) begin
         tick();
         if (done3 && lat3 < 0) lat3 = cyc - s0;
         if (done0 && lat0 < 0) lat0 = cyc - s0;
         if (i == 2) load = 1'b0;
      end
      chk("latency_after_abort_lat3", lat3, 82);
      chk("latency_after_abort_lat0", lat0, 22);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
